row_sel_stream: RTL

- Parametrised row selector for the LPN PUF datapath (Gen and Ver).
- Accepts matrix-A rows over a valid/ready stream and keeps only the rows whose index bit is set, up to a programmable count.
- Once full, streams the stored rows out column by column (transposed) to the downstream multiplier, with full handshaking.
- Adds over the previous generation: generic widths/depths, backpressure on both sides, abort/restart, and a short-index error flag.

---
 rtl/row_sel_stream.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/row_sel_stream.sv
// -----------------------------------------------------------------------------
// row_sel_stream
//
// Row selector for the LPN PUF datapath (Gen and Ver). Matrix-A rows arrive
// on a valid/ready stream. Only the rows whose selection bit is set are kept,
// up to num_sel rows. The stored rows are then streamed out column by column
// (transposed) to the downstream multiplier.
//
// Handshake semantics, both stream ports: a transfer happens on a rising clk
// edge where valid and ready are both high. A producer holds its data stable
// while valid is high and ready is low. row_ready is high for the whole SEL
// state. col_valid is high for the whole OUT state.
//
// Optional feature, macro ROW_SEL_BYPASS_EN: adds the 'bypass' input. While
// in SEL with bypass=1, every accepted row is selected and the bitmap still
// shifts. When the macro is undefined, selection uses the bitmap only.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   idx_valid              strobe: load idx_in/num_sel, (re)start a run
//   idx_in[IDX_W]          selection bitmap, MSB applies to the first row
//   num_sel[CNT_W]         rows to select (clamped to SEL_MAX)
//   bypass                 (ROW_SEL_BYPASS_EN only) select every row
//   row_valid/row_ready    input row stream
//   row_in[ROW_W]          matrix row
//   col_valid/col_ready    output column stream
//   col_out[SEL_MAX]       column word, bit i = bit 0 of storage slot i
//   done                   high throughout OUT
//   half_done              the next accepted row completes the selection
//   short_err              sticky: bitmap ran out before num_sel rows
//   dbg_state[2]           FSM state (0 IDLE, 1 SEL, 2 OUT)
// -----------------------------------------------------------------------------
module row_sel_stream #(
    parameter  int ROW_W   = 128,
    parameter  int SEL_MAX = 128,
    parameter  int IDX_W   = 450,
    localparam int CNT_W   = $clog2(SEL_MAX + 1)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               idx_valid,
    input  logic [IDX_W-1:0]   idx_in,
    input  logic [CNT_W-1:0]   num_sel,
`ifdef ROW_SEL_BYPASS_EN
    input  logic               bypass,
`endif
    input  logic               row_valid,
    output logic               row_ready,
    input  logic [ROW_W-1:0]   row_in,
    output logic               col_valid,
    input  logic               col_ready,
    output logic [SEL_MAX-1:0] col_out,
    output logic               done,
    output logic               half_done,
    output logic               short_err,
    output logic [1:0]         dbg_state
);

    localparam int SEEN_W = $clog2(IDX_W + 1);
    localparam int COL_W  = $clog2(ROW_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEL  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t                          r_state;
    logic [SEL_MAX-1:0][ROW_W-1:0]   r_store;
    logic [IDX_W-1:0]                r_bitmap;
    logic [CNT_W-1:0]                r_num_sel;
    logic [CNT_W-1:0]                r_cnt;
    logic [SEEN_W-1:0]               r_rows_seen;
    logic [COL_W-1:0]                r_col_cnt;
    logic                            r_short_err;

    logic [CNT_W-1:0]                w_num_clamp;
    logic [CNT_W-1:0]                w_cnt_next;
    logic [SEEN_W-1:0]               w_seen_next;
    logic                            w_sel_bit;
    logic [SEL_MAX-1:0]              w_col;

    assign w_num_clamp = (num_sel > CNT_W'(SEL_MAX)) ? CNT_W'(SEL_MAX) : num_sel;
    assign w_cnt_next  = r_cnt + CNT_W'(1);
    assign w_seen_next = r_rows_seen + SEEN_W'(1);

`ifdef ROW_SEL_BYPASS_EN
    assign w_sel_bit = r_bitmap[IDX_W-1] | bypass;
`else
    assign w_sel_bit = r_bitmap[IDX_W-1];
`endif

    // Column word: bit 0 of every slot. Slots shift right as columns drain,
    // so this always presents the next unconsumed column.
    always_comb begin
        w_col = '0;
        for (int i = 0; i < SEL_MAX; i++) begin
            w_col[i] = r_store[i][0];
        end
    end

    assign col_out   = w_col;
    assign row_ready = (r_state == ST_SEL);
    assign col_valid = (r_state == ST_OUT);
    assign done      = (r_state == ST_OUT);
    assign short_err = r_short_err;
    assign dbg_state = r_state;

    // Looks only at the current row's selection bit, not at row_valid, so
    // downstream can prepare before the completing row is actually offered.
    assign half_done = (r_state == ST_SEL) && w_sel_bit &&
                       (r_cnt == r_num_sel - CNT_W'(1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_store     <= '0;
            r_bitmap    <= '0;
            r_num_sel   <= '0;
            r_cnt       <= '0;
            r_rows_seen <= '0;
            r_col_cnt   <= '0;
            r_short_err <= 1'b0;
        end else if (idx_valid) begin
            // A new index aborts any run in progress and wins over any
            // row or column handshake in the same cycle.
            r_store     <= '0;
            r_bitmap    <= idx_in;
            r_num_sel   <= w_num_clamp;
            r_cnt       <= '0;
            r_rows_seen <= '0;
            r_col_cnt   <= '0;
            if (w_num_clamp == '0) begin
                r_short_err <= 1'b1;
                r_state     <= ST_IDLE;
            end else begin
                r_short_err <= 1'b0;
                r_state     <= ST_SEL;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                end
                ST_SEL: begin
                    if (row_valid) begin
                        r_bitmap    <= r_bitmap << 1;
                        r_rows_seen <= w_seen_next;
                        if (w_sel_bit) begin
                            // New row enters slot 0 and older rows move up,
                            // so the first-selected row ends in slot n-1.
                            r_store <= {r_store[SEL_MAX-2:0], row_in};
                            r_cnt   <= w_cnt_next;
                        end
                        if (w_sel_bit && (w_cnt_next == r_num_sel)) begin
                            r_state <= ST_OUT;
                        end else if (w_seen_next == SEEN_W'(IDX_W)) begin
                            r_short_err <= 1'b1;
                            r_state     <= ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    if (col_ready) begin
                        if (r_col_cnt == COL_W'(ROW_W - 1)) begin
                            r_store   <= '0;
                            r_col_cnt <= '0;
                            r_state   <= ST_IDLE;
                        end else begin
                            for (int i = 0; i < SEL_MAX; i++) begin
                                r_store[i] <= r_store[i] >> 1;
                            end
                            r_col_cnt <= r_col_cnt + COL_W'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
